// File: rtl/cla_pkg.sv
// Shared definitions for the CLA stimulus generator: FSM encoding,
// LFSR geometry and taps, and the operand-pairing mode encodings.
package cla_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Fibonacci LFSR, polynomial x^128 + x^126 + x^101 + x^99 + 1.
    // Tap bit indices are (exponent - 1) on a left-shifting register.
    localparam int LFSR_W     = 128;
    localparam int LFSR_TAP_A = 127;
    localparam int LFSR_TAP_B = 125;
    localparam int LFSR_TAP_C = 100;
    localparam int LFSR_TAP_D = 98;

    // Operand pairing: complement gives an all-ones sum, swap exercises
    // long carry chains across the half boundary.
    localparam logic MODE_CPL  = 1'b0;
    localparam logic MODE_SWAP = 1'b1;

    // One LFSR step: shift left, feedback enters bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
    endfunction

endpackage

// File: rtl/cla_delay_line.sv
// Valid+data shift register of fixed depth. The valid bits are cleared by a
// synchronous flush; data bits carry no reset and are qualified by valid.
module cla_delay_line #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             flush,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat,
    output logic             pending
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [WIDTH-1:0] dat_q [DEPTH];
    logic [WIDTH-1:0] dat_d [DEPTH];

    // Next stage contents: everything moves one slot toward the output.
    always_comb begin
        vld_d[0] = in_vld;
        dat_d[0] = in_dat;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
        if (flush) begin
            vld_d = '0;
        end
    end

    // Stage registers; flush already folded into vld_d.
    always_ff @(posedge clk) begin
        vld_q <= vld_d;
        dat_q <= dat_d;
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_dat = dat_q[DEPTH-1];

    // Something still upstream of the output stage, i.e. the line will not
    // be empty after the next edge.
    generate
        if (DEPTH > 1) begin : g_pend
            assign pending = |vld_q[DEPTH-2:0];
        end else begin : g_nopend
            assign pending = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/cla_stimulus_gen.sv
// Burst stimulus generator for a pipelined carry-lookahead adder. Emits LFSR
// operand pairs with valid/ready handshake and the expected sum delayed by
// the adder latency so it lines up with the adder output.
module cla_stimulus_gen
    import cla_pkg::*;
#(
    parameter int         W    = 128,
    parameter int         LAT  = 4,
    parameter logic [W-1:0] SEED = 128'h1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [15:0]  count,
    input  logic         mode,
    output logic [W-1:0] op1,
    output logic [W-1:0] op2,
    output logic         valid_op,
    input  logic         ready,
    output logic [W-1:0] exp_sum,
    output logic         exp_valid,
    output logic         busy,
    output logic         done,
    output logic [15:0]  sent
);

    state_e              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [15:0]         sent_q, sent_d;
    logic [15:0]         count_q, count_d;
    logic                mode_q, mode_d;

    logic [W-1:0]        op1_raw, op2_raw, sum_raw;
    logic                run_vld, xfer, last_xfer;
    logic                dl_vld, dl_pending;
    logic [W-1:0]        dl_dat;

    assign run_vld   = (state_q == ST_RUN);
    assign xfer      = run_vld & ready;
    // Widened compare so count = 16'hFFFF cannot wrap.
    assign last_xfer = xfer && (({1'b0, sent_q} + 17'd1) == {1'b0, count_q});

    assign op1_raw = W'(lfsr_q);
    assign sum_raw = op1_raw + op2_raw;

    // Operand pairing selected by the latched mode.
    always_comb begin
        op2_raw = ~op1_raw;
        case (mode_q)
            MODE_CPL:  op2_raw = ~op1_raw;
            MODE_SWAP: op2_raw = {op1_raw[W/2-1:0], op1_raw[W-1:W/2]};
        endcase
    end

    // State and datapath registers; reset overrides start and transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lfsr_q  <= LFSR_W'(SEED);
            sent_q  <= '0;
            count_q <= '0;
            mode_q  <= MODE_CPL;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            sent_q  <= sent_d;
            count_q <= count_d;
            mode_q  <= mode_d;
        end
    end

    // Burst sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  state_d = (count_q == 16'd0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (last_xfer) state_d = ST_DRAIN;
            ST_DRAIN: if (!dl_pending) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Burst parameters, LFSR and transfer counter updates.
    always_comb begin
        lfsr_d  = lfsr_q;
        sent_d  = sent_q;
        count_d = count_q;
        mode_d  = mode_q;
        if (state_q == ST_IDLE && start) begin
            count_d = count;
            mode_d  = mode;
        end
        if (state_q == ST_LOAD) begin
            lfsr_d = LFSR_W'(SEED);
            sent_d = '0;
        end
        if (xfer) begin
            lfsr_d = lfsr_step(lfsr_q);
            sent_d = sent_q + 16'd1;
        end
    end

    // Outputs; operand and sum buses read zero when not qualified.
    always_comb begin
        valid_op  = run_vld;
        op1       = run_vld ? op1_raw : '0;
        op2       = run_vld ? op2_raw : '0;
        exp_valid = dl_vld;
        exp_sum   = dl_vld ? dl_dat : '0;
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        sent      = sent_q;
    end

    cla_delay_line #(
        .WIDTH (W),
        .DEPTH (LAT)
    ) u_exp_line (
        .clk     (clk),
        .flush   (rst),
        .in_vld  (xfer),
        .in_dat  (sum_raw),
        .out_vld (dl_vld),
        .out_dat (dl_dat),
        .pending (dl_pending)
    );

endmodule
